// File: rtl/ifu_fetch_pkg.sv
// Shared constants, FSM state type and helpers for the instruction fetch stage.
package ifu_fetch_pkg;

  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous fetch buffer of {addr, inst} entries; flush overrides push and pop.
module ifu_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ifu_fetch.sv
// Fetch stage: owns the PC, keeps one imem request in flight, buffers returned
// words with their addresses and presents the buffer head to if_id.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_data_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  // Request port: a request transfers on a cycle where valid and ready are both
  // high; valid never depends on ready. Responses arrive in order, one per request.

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic             drop_q, drop_d;

  logic             can_req, req_hs;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [63:0]      fifo_head;

  // drop_q also blocks new requests so a stale pre-reset response can never
  // be paired with a fresh request.
  assign can_req          = (state_q == S_REQ) && !drop_q &&
                            (fifo_count < CNT_W'(FIFO_DEPTH));
  assign req_hs           = can_req && imem_req_ready_i;
  assign imem_req_valid_o = can_req;
  assign imem_req_addr_o  = pc_q;

  assign inst_valid_o = !fifo_empty;
  assign inst_o       = inst_valid_o ? fifo_head[31:0]  : INST_NOP;
  assign inst_addr_o  = inst_valid_o ? fifo_head[63:32] : ZERO_WORD;
  assign fifo_pop     = inst_valid_o && !hold_flag_i && !jump_en_i;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    drop_d     = drop_q;
    fifo_push  = 1'b0;

    // A stale response outside WAIT only retires the pending drop.
    if (drop_q && imem_resp_valid_i && (state_q != S_WAIT)) drop_d = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (req_hs) begin
          pc_d       = pc_q + 32'd4;
          req_addr_d = pc_q;
          state_d    = S_WAIT;
          if (jump_en_i) drop_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid_i) begin
          fifo_push = !drop_q && !jump_en_i && (!fifo_full || fifo_pop);
          drop_d    = 1'b0;
          state_d   = S_REQ;
        end else if (jump_en_i) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (jump_en_i) pc_d = word_align(jump_addr_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= ZERO_WORD;
      drop_q     <= (state_q == S_WAIT) && !imem_resp_valid_i;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      drop_q     <= drop_d;
    end
  end

  ifu_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (jump_en_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  ({req_addr_q, imem_resp_data_i}),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: an imem model with configurable latency plus a scoreboard
// of the {addr, inst} entries the fetch buffer must hold.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_en_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        hold_flag_i = 1'b0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b1;
  logic [31:0] imem_req_addr_o;
  logic        imem_resp_valid_i = 1'b0;
  logic [31:0] imem_resp_data_i = '0;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .jump_en_i         (jump_en_i),
    .jump_addr_i       (jump_addr_i),
    .hold_flag_i       (hold_flag_i),
    .imem_req_valid_o  (imem_req_valid_o),
    .imem_req_ready_i  (imem_req_ready_i),
    .imem_req_addr_o   (imem_req_addr_o),
    .imem_resp_valid_i (imem_resp_valid_i),
    .imem_resp_data_i  (imem_resp_data_i),
    .inst_o            (inst_o),
    .inst_addr_o       (inst_addr_o),
    .inst_valid_o      (inst_valid_o)
  );

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        out_valid  = 1'b0;
  logic        out_killed = 1'b0;
  logic [31:0] out_addr   = '0;
  int          out_wait   = 0;
  int          lat        = 1;
  logic [31:0] exp_pc     = RST_PC;
  logic        was_rst    = 1'b1;
  logic        ckon       = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle, entered and left at a falling edge. Scripted inputs
  // (rst, hold, jump, ready) must be set before the call.
  task automatic step();
    logic resp, hs, empty_m;
    empty_m = (exp_q.size() == 0);
    if (ckon) begin
      check("inst_valid", inst_valid_o, !empty_m);
      if (!empty_m) check("head", {inst_addr_o, inst_o}, exp_q[0]);
      else          check("idle_out", {inst_addr_o, inst_o}, {ZERO_WORD, INST_NOP});
      check("req_valid", imem_req_valid_o,
            !was_rst && !out_valid && (exp_q.size() < DEPTH));
      if (imem_req_valid_o) check("req_addr", imem_req_addr_o, exp_pc);
    end
    resp = out_valid && (out_wait == 0);
    imem_resp_valid_i = resp;
    imem_resp_data_i  = resp ? mem_word(out_addr) : $urandom();
    hs = ckon && !rst && imem_req_valid_o && imem_req_ready_i;

    if (!rst && !empty_m && !hold_flag_i && !jump_en_i) void'(exp_q.pop_front());
    if (rst || jump_en_i) begin
      exp_q.delete();
      if (out_valid) out_killed = 1'b1;
    end
    if (resp) begin
      if (!out_killed) exp_q.push_back({out_addr, mem_word(out_addr)});
      out_valid = 1'b0;
    end else if (out_valid) begin
      out_wait--;
    end
    if (hs) begin
      out_valid  = 1'b1;
      out_addr   = imem_req_addr_o;
      out_killed = jump_en_i;
      out_wait   = lat - 1;
      exp_pc     = exp_pc + 32'd4;
    end
    if (rst)            exp_pc = RST_PC;
    else if (jump_en_i) exp_pc = {jump_addr_i[31:2], 2'b00};
    was_rst = rst;
    if (rst) ckon = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until a request is outstanding; want_resp selects whether its
  // response is due in the next step.
  task automatic wait_outstanding(input string tag, input logic want_resp);
    int guard = 0;
    while (!(out_valid && ((out_wait == 0) == want_resp)) && guard < 40) begin
      step();
      guard++;
    end
    check(tag, guard < 40, 1'b1);
  endtask

  task automatic wait_req_valid(input string tag);
    int guard = 0;
    while (!imem_req_valid_o && guard < 40) begin
      step();
      guard++;
    end
    check(tag, guard < 40, 1'b1);
  endtask

  task automatic pulse_jump(input logic [31:0] addr);
    jump_en_i = 1'b1;
    jump_addr_i = addr;
    step();
    jump_en_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);
    rst = 1'b1;
    run(2);
    rst = 1'b0;

    // Straight-line fetch, latency 1, memory always ready.
    lat = 1;
    run(12);

    // Hold: buffer fills and requests stop; then drain in order.
    hold_flag_i = 1'b1;
    run(8);
    hold_flag_i = 1'b0;
    run(10);

    // Jump while waiting for a response; that response is dropped.
    lat = 2;
    wait_outstanding("wait_for_wait", 1'b0);
    pulse_jump(32'h8000_0103);
    run(10);

    // Jump coinciding with a response.
    lat = 1;
    wait_outstanding("wait_for_resp", 1'b1);
    pulse_jump(32'h8000_0200);
    run(8);

    // Jump coinciding with a request handshake.
    wait_req_valid("wait_for_req");
    pulse_jump(32'h8000_0300);
    run(8);

    // Memory stalls the request for three cycles.
    wait_req_valid("wait_for_stall");
    imem_req_ready_i = 1'b0;
    run(3);
    imem_req_ready_i = 1'b1;
    run(8);

    // Reset while a request is outstanding.
    lat = 3;
    wait_outstanding("wait_for_rst", 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(15);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      imem_req_ready_i = ($urandom_range(0, 3) != 0);
      hold_flag_i      = ($urandom_range(0, 2) == 0);
      jump_en_i        = ($urandom_range(0, 15) == 0);
      jump_addr_i      = $urandom();
      rst              = ($urandom_range(0, 149) == 0);
      lat              = $urandom_range(1, 3);
      step();
    end
    jump_en_i = 1'b0;
    rst = 1'b0;
    hold_flag_i = 1'b0;
    imem_req_ready_i = 1'b1;
    run(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
